// File: rtl/regincr_out_fifo.sv
// rtl/regincr_out_fifo.sv - capture FIFO behind the registered incrementer with drop counting
module regincr_out_fifo #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_val,
    input  logic [7:0]       in_msg,
    output logic             out_val,
    input  logic             out_rdy,
    output logic [7:0]       out_msg,
    output logic [CNT_W-1:0] count,
    output logic [7:0]       drops,
    output logic             overflow
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             full;
    logic             deq;
    logic             enq;
    logic             drop;

    // Handshake decode; a full FIFO can still accept when its head leaves this cycle
    always_comb begin
        full    = (count == CNT_W'(DEPTH));
        out_val = (count != '0);
        out_msg = mem[rd_ptr];
        deq     = out_val && out_rdy;
        enq     = in_val && (!full || deq);
        drop    = in_val && !enq;
    end

    // Storage array; not reset since entries are only visible once counted
    always_ff @(posedge clk) begin
        if (enq) begin
            mem[wr_ptr] <= in_msg;
        end
    end

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({enq, deq})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Drop accounting: saturating counter plus a sticky flag cleared only by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drops    <= '0;
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drops != 8'hFF) begin
                drops <= drops + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_regincr_out_fifo.sv
// tb/tb_regincr_out_fifo.sv - directed self-checking bench for regincr_out_fifo
module tb_regincr_out_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_val;
    logic [7:0] in_msg;
    logic       out_val;
    logic       out_rdy;
    logic [7:0] out_msg;
    logic [2:0] count;
    logic [7:0] drops;
    logic       overflow;

    int checks   = 0;
    int failures = 0;

    regincr_out_fifo #(.DEPTH(4), .CNT_W(3)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_val   (in_val),
        .in_msg   (in_msg),
        .out_val  (out_val),
        .out_rdy  (out_rdy),
        .out_msg  (out_msg),
        .count    (count),
        .drops    (drops),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; in_val = 1'b0; in_msg = 8'h00; out_rdy = 1'b0;
        step(); step();
        reset = 1'b1;
        step();
        checks++; if (out_val !== 1'b0) begin failures++; $display("FAIL reset_out_val got=%b exp=0", out_val); end
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (drops !== 8'h00) begin failures++; $display("FAIL reset_drops got=%h exp=00", drops); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    endtask

    task automatic test_fill_drain();
        out_rdy = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            in_val = 1'b1; in_msg = 8'(i);
            step();
        end
        in_val = 1'b0;
        checks++; if (count !== 3'd4) begin failures++; $display("FAIL fill_count got=%0d exp=4", count); end
        step(); step();
        checks++; if (out_msg !== 8'h01 || out_val !== 1'b1) begin failures++; $display("FAIL stall_hold got=%h/%b exp=01/1", out_msg, out_val); end
        out_rdy = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            checks++; if (out_val !== 1'b1 || out_msg !== 8'(i)) begin failures++; $display("FAIL drain_order got=%h/%b exp=%h/1", out_msg, out_val, 8'(i)); end
            step();
        end
        checks++; if (out_val !== 1'b0 || count !== 3'd0) begin failures++; $display("FAIL drain_empty got=%b/%0d exp=0/0", out_val, count); end
        step();
        checks++; if (out_val !== 1'b0 || count !== 3'd0) begin failures++; $display("FAIL empty_rdy got=%b/%0d exp=0/0", out_val, count); end
        out_rdy = 1'b0;
    endtask

    task automatic test_overflow();
        out_rdy = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            in_val = 1'b1; in_msg = 8'(i);
            step();
        end
        in_val = 1'b0;
        checks++; if (drops !== 8'd2) begin failures++; $display("FAIL ovf_drops got=%0d exp=2", drops); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
        checks++; if (count !== 3'd4) begin failures++; $display("FAIL ovf_count got=%0d exp=4", count); end
        out_rdy = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            checks++; if (out_val !== 1'b1 || out_msg !== 8'(i)) begin failures++; $display("FAIL ovf_drain got=%h/%b exp=%h/1", out_msg, out_val, 8'(i)); end
            step();
        end
        out_rdy = 1'b0;
        checks++; if (out_val !== 1'b0) begin failures++; $display("FAIL ovf_empty got=%b exp=0", out_val); end
    endtask

    task automatic test_pass_through();
        logic [7:0] exp_seq [10];
        exp_seq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
        out_rdy = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            in_val = 1'b1; in_msg = 8'(i);
            step();
        end
        for (int k = 0; k < 6; k++) begin
            in_val = 1'b1; in_msg = 8'h10 + 8'(k); out_rdy = 1'b1;
            checks++; if (out_msg !== exp_seq[k]) begin failures++; $display("FAIL pass_order got=%h exp=%h", out_msg, exp_seq[k]); end
            step();
            checks++; if (count !== 3'd4) begin failures++; $display("FAIL pass_count got=%0d exp=4", count); end
        end
        in_val = 1'b0;
        for (int k = 6; k < 10; k++) begin
            checks++; if (out_val !== 1'b1 || out_msg !== exp_seq[k]) begin failures++; $display("FAIL pass_tail got=%h/%b exp=%h/1", out_msg, out_val, exp_seq[k]); end
            step();
        end
        out_rdy = 1'b0;
        checks++; if (out_val !== 1'b0 || drops !== 8'd2) begin failures++; $display("FAIL pass_end got=%b/%0d exp=0/2", out_val, drops); end
    endtask

    task automatic test_saturation();
        out_rdy = 1'b0;
        for (int i = 0; i < 300; i++) begin
            in_val = 1'b1; in_msg = 8'(i);
            step();
            if (i == 255) begin
                checks++; if (drops !== 8'd254) begin failures++; $display("FAIL sat_near got=%0d exp=254", drops); end
            end
        end
        in_val = 1'b0;
        checks++; if (drops !== 8'hFF) begin failures++; $display("FAIL sat_drops got=%h exp=ff", drops); end
        checks++; if (overflow !== 1'b1 || count !== 3'd4) begin failures++; $display("FAIL sat_state got=%b/%0d exp=1/4", overflow, count); end
        out_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++; if (out_msg !== 8'(k)) begin failures++; $display("FAIL sat_drain got=%h exp=%h", out_msg, 8'(k)); end
            step();
        end
        out_rdy = 1'b0;
        // rounds of three move the pointers off zero so later rounds wrap mid-array
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 3; k++) begin
                in_val = 1'b1; in_msg = 8'h20 + 8'(r * 3 + k);
                step();
            end
            in_val = 1'b0; out_rdy = 1'b1;
            for (int k = 0; k < 3; k++) begin
                checks++; if (out_val !== 1'b1 || out_msg !== 8'h20 + 8'(r * 3 + k)) begin failures++; $display("FAIL wrap_order got=%h/%b exp=%h/1", out_msg, out_val, 8'h20 + 8'(r * 3 + k)); end
                step();
            end
            out_rdy = 1'b0;
            checks++; if (count !== 3'd0) begin failures++; $display("FAIL wrap_count got=%0d exp=0", count); end
        end
        for (int k = 0; k < 4; k++) begin
            in_val = 1'b1; in_msg = 8'h40 + 8'(k);
            step();
        end
        in_val = 1'b0;
        checks++; if (count !== 3'd4 || drops !== 8'hFF) begin failures++; $display("FAIL wrap_full got=%0d/%h exp=4/ff", count, drops); end
        out_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++; if (out_msg !== 8'h40 + 8'(k)) begin failures++; $display("FAIL wrap_full_order got=%h exp=%h", out_msg, 8'h40 + 8'(k)); end
            step();
        end
        out_rdy = 1'b0;
    endtask

    task automatic test_async_reset();
        out_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_val = 1'b1; in_msg = 8'hA1 + 8'(k);
            step();
        end
        in_val = 1'b0;
        checks++; if (count !== 3'd3) begin failures++; $display("FAIL areset_pre got=%0d exp=3", count); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if (count !== 3'd0 || out_val !== 1'b0) begin failures++; $display("FAIL areset_clear got=%0d/%b exp=0/0", count, out_val); end
        checks++; if (drops !== 8'h00 || overflow !== 1'b0) begin failures++; $display("FAIL areset_drops got=%h/%b exp=00/0", drops, overflow); end
        step(); step();
        reset = 1'b1; in_val = 1'b1; in_msg = 8'hAA;
        step();
        in_val = 1'b0;
        checks++; if (count !== 3'd1 || out_msg !== 8'hAA || out_val !== 1'b1) begin failures++; $display("FAIL areset_first got=%0d/%h/%b exp=1/aa/1", count, out_msg, out_val); end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_overflow();
        test_pass_through();
        test_saturation();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
